// File: rtl/ram_rd_chk.sv
// Read-side checker for the RAM test controller: realigns the controller's
// address stream with registered RAM read data and checks data == address.
module ram_rd_chk #(
  parameter int RD_LAT = 2,
  parameter int ADDR_W = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] rd_data,
  output logic [ADDR_W-1:0] data_out,
  output logic              data_vld,
  output logic [ADDR_W:0]   err_cnt,
  output logic              pass,
  output logic              fail,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] a;
  } cmp_t;

  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  state_t state, state_nxt;

  logic                         rd_en_d;
  logic [ADDR_W-1:0]            addr_d;
  logic                         stb;
  logic [RD_LAT:1]              vld_pipe;
  logic [RD_LAT:1][ADDR_W-1:0]  a_pipe;
  logic [ADDR_W-1:0]            exp_addr;

  cmp_t                         cmp;
  logic                         start;
  logic                         last;
  logic                         err;
  logic [ADDR_W:0]              err_sum;

  // One strobe per address step; a held address produces a single strobe.
  assign stb = rd_en & ~wr_en & (~rd_en_d | (addr != addr_d));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_en_d <= 1'b0;
      addr_d  <= '0;
    end else begin
      rd_en_d <= rd_en;
      addr_d  <= addr;
    end
  end

  // Delay strobe/address by the RAM read latency so they meet rd_data.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_pipe <= '0;
      a_pipe   <= '0;
    end else if (wr_en) begin
      vld_pipe <= '0;
      a_pipe   <= '0;
    end else begin
      vld_pipe[1] <= stb;
      a_pipe[1]   <= addr;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        a_pipe[i]   <= a_pipe[i-1];
      end
    end
  end

  assign cmp.vld = vld_pipe[RD_LAT];
  assign cmp.a   = a_pipe[RD_LAT];

  // Address 0 starts a sweep by definition, so only its data is checked.
  assign start   = cmp.vld & (cmp.a == '0);
  assign last    = cmp.vld & (cmp.a == LAST);
  assign err     = (rd_data != cmp.a) | (~start & (cmp.a != exp_addr));
  assign err_sum = err_cnt + {{ADDR_W{1'b0}}, err};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (wr_en) begin
      state_nxt = IDLE;
    end else if (cmp.vld) begin
      case (state)
        IDLE:    if (start) state_nxt = SWEEP;
        SWEEP:   if (start) state_nxt = SWEEP;
                 else if (last) state_nxt = DONE;
        DONE:    if (start) state_nxt = SWEEP;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == SWEEP);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      data_out <= '0;
      data_vld <= 1'b0;
      err_cnt  <= '0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      exp_addr <= '0;
    end else if (wr_en) begin
      data_vld <= 1'b0;
      err_cnt  <= '0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      exp_addr <= '0;
    end else begin
      data_vld <= cmp.vld;
      if (cmp.vld) data_out <= rd_data;
      if (start) begin
        err_cnt  <= {{ADDR_W{1'b0}}, err};
        exp_addr <= ADDR_W'(1);
      end else if (cmp.vld && state == SWEEP) begin
        err_cnt  <= err_sum;
        exp_addr <= cmp.a + ADDR_W'(1);
        if (last) begin
          pass <= (err_sum == '0);
          fail <= (err_sum != '0);
        end
      end
    end
  end

endmodule
